// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR word source with a valid/ready pull interface, runtime reseed,
// warm-up discard and draw counter. Define LFSR_LOCKUP_RECOVER_EN to replace all-zero states by SEED.
module lfsr_gen #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(32'hACE1_1234),
  parameter int               STEP   = 1,
  parameter int               WARMUP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [31:0]      draw_cnt,
  output logic             lockup
);

  localparam logic [0:0] ST_WARM   = 1'b0;
  localparam logic [0:0] ST_READY  = 1'b1;
  localparam logic [0:0] ST_INIT   = (WARMUP > 0) ? ST_WARM : ST_READY;
  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] adv_raw;
  logic [WIDTH-1:0] adv_next;
  logic [WIDTH-1:0] load_next;
  logic [0:0]       fsm;
  logic [7:0]       warm_cnt;
  logic             do_load;
  logic             do_adv;

  // STEP single-bit shifts unrolled into one combinational advance.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    // NOTE: blocking '=' here on purpose: each shift must see the previous shift's result.
    v = s;
    for (int i = 0; i < STEP; i++) v = {v[WIDTH-2:0], ^(v & TAPS)};
    return v;
  endfunction

  assign adv_raw  = advance(state);
  assign rd_valid = ~rst & en & (fsm == ST_READY);
  assign rd_data  = state;

  // seed_load wins over a coincident transfer; the transfer is then neither counted nor applied.
  assign do_load = en & seed_load;
  assign do_adv  = en & ~seed_load & ((fsm == ST_WARM) ? (warm_cnt != 8'd0) : rd_ready);

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign adv_next  = (adv_raw == '0)  ? SEED : adv_raw;
  assign load_next = (seed_val == '0) ? SEED : seed_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockup <= 1'b0;
    end else if ((do_adv && adv_raw == '0) || (do_load && seed_val == '0)) begin
      lockup <= 1'b1;
    end
  end
`else
  assign adv_next  = adv_raw;
  assign load_next = seed_val;
  assign lockup    = 1'b0;
`endif

  // NOTE: sequential state uses '<=' only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEED;
      fsm      <= ST_INIT;
      warm_cnt <= WARM_INIT;
      draw_cnt <= '0;
    end else if (do_load) begin
      state    <= load_next;
      fsm      <= ST_INIT;
      warm_cnt <= WARM_INIT;
      draw_cnt <= '0;
    end else if (en) begin
      if (do_adv) state <= adv_next;
      if (fsm == ST_WARM) begin
        // The last discard and the move to READY share an edge, so rd_valid rises
        // exactly WARMUP enabled cycles after entering WARM.
        if (warm_cnt <= 8'd1) fsm <= ST_READY;
        if (warm_cnt != 8'd0) warm_cnt <= warm_cnt - 8'd1;
      end else if (rd_ready) begin
        draw_cnt <= draw_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for lfsr_gen; default, STEP=4 and WARMUP=3 instances.
// Expected words come from an independent bit-serial LFSR model in the bench.
module tb_lfsr_gen;

  localparam logic [31:0] TAPS_C = 32'h8020_0003;
  localparam logic [31:0] SEED_C = 32'hACE1_1234;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        en_a = 1'b0, seed_load_a = 1'b0, rd_ready_a = 1'b0;
  logic [31:0] seed_val_a = '0;
  logic        rd_valid_a, lockup_a;
  logic [31:0] rd_data_a, draw_cnt_a;
  // STEP=4 instance
  logic        en_s = 1'b1, seed_load_s = 1'b0, rd_ready_s = 1'b0;
  logic [31:0] seed_val_s = '0;
  logic        rd_valid_s, lockup_s;
  logic [31:0] rd_data_s, draw_cnt_s;
  // WARMUP=3 instance
  logic        en_w = 1'b0, seed_load_w = 1'b0, rd_ready_w = 1'b0;
  logic [31:0] seed_val_w = '0;
  logic        rd_valid_w, lockup_w;
  logic [31:0] rd_data_w, draw_cnt_w;

  lfsr_gen u_dut (
    .clk(clk), .rst(rst), .en(en_a), .seed_load(seed_load_a), .seed_val(seed_val_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a), .rd_data(rd_data_a),
    .draw_cnt(draw_cnt_a), .lockup(lockup_a)
  );

  lfsr_gen #(.STEP(4)) u_step4 (
    .clk(clk), .rst(rst), .en(en_s), .seed_load(seed_load_s), .seed_val(seed_val_s),
    .rd_valid(rd_valid_s), .rd_ready(rd_ready_s), .rd_data(rd_data_s),
    .draw_cnt(draw_cnt_s), .lockup(lockup_s)
  );

  lfsr_gen #(.WARMUP(3)) u_warm (
    .clk(clk), .rst(rst), .en(en_w), .seed_load(seed_load_w), .seed_val(seed_val_w),
    .rd_valid(rd_valid_w), .rd_ready(rd_ready_w), .rd_data(rd_data_w),
    .draw_cnt(draw_cnt_w), .lockup(lockup_w)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [31:0] mdl_a;
  logic [31:0] cnt_a;

  // Bit-serial reference: walk the tap mask one bit at a time.
  function automatic logic [31:0] ref_shift(input logic [31:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 32; i++) if (TAPS_C[i]) fb = fb ^ s[i];
    return {s[30:0], fb};
  endfunction

  function automatic logic [31:0] ref_adv(input logic [31:0] s, input int n);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = ref_shift(v);
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output logic [31:0] e);
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty: got empty queue, required an entry");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b1; en_w = 1'b1;
    @(negedge clk);
    n_checks++; if (rd_valid_a !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b required 0", rd_valid_a); end
    n_checks++; if (rd_data_a !== SEED_C) begin n_errors++; $display("FAIL reset_data: got %h required %h", rd_data_a, SEED_C); end
    n_checks++; if (draw_cnt_a !== 32'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d required 0", draw_cnt_a); end
    n_checks++; if (lockup_a !== 1'b0) begin n_errors++; $display("FAIL reset_lockup: got %b required 0", lockup_a); end
    n_checks++; if (rd_valid_w !== 1'b0) begin n_errors++; $display("FAIL reset_valid_warm: got %b required 0", rd_valid_w); end
    en_w = 1'b0;
    next_cycle();
    rst = 1'b0;
    mdl_a = SEED_C; cnt_a = 0;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    rd_ready_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mdl_a);
      @(negedge clk);
      pop_exp(e);
      n_checks++; if (rd_valid_a !== 1'b1) begin n_errors++; $display("FAIL stream_valid[%0d]: got %b required 1", i, rd_valid_a); end
      n_checks++; if (rd_data_a !== e) begin n_errors++; $display("FAIL stream_data[%0d]: got %h required %h", i, rd_data_a, e); end
      n_checks++; if (draw_cnt_a !== cnt_a) begin n_errors++; $display("FAIL stream_cnt[%0d]: got %0d required %0d", i, draw_cnt_a, cnt_a); end
      if (i == 1) begin
        n_checks++; if (rd_data_a !== 32'h59C2_2468) begin n_errors++; $display("FAIL stream_second_word: got %h required 59c22468", rd_data_a); end
      end
      mdl_a = ref_shift(mdl_a); cnt_a++;
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    rd_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (rd_valid_a !== 1'b1) begin n_errors++; $display("FAIL bp_valid[%0d]: got %b required 1", i, rd_valid_a); end
      n_checks++; if (rd_data_a !== mdl_a) begin n_errors++; $display("FAIL bp_hold[%0d]: got %h required %h", i, rd_data_a, mdl_a); end
      n_checks++; if (draw_cnt_a !== cnt_a) begin n_errors++; $display("FAIL bp_cnt[%0d]: got %0d required %0d", i, draw_cnt_a, cnt_a); end
      next_cycle();
    end
    rd_ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mdl_a);
      @(negedge clk);
      pop_exp(e);
      n_checks++; if (rd_data_a !== e) begin n_errors++; $display("FAIL bp_resume[%0d]: got %h required %h", i, rd_data_a, e); end
      n_checks++; if (draw_cnt_a !== cnt_a) begin n_errors++; $display("FAIL bp_resume_cnt[%0d]: got %0d required %0d", i, draw_cnt_a, cnt_a); end
      mdl_a = ref_shift(mdl_a); cnt_a++;
      next_cycle();
    end
  endtask

  task automatic test_enable_freeze();
    logic [31:0] e;
    en_a = 1'b0; rd_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // A seed_load while disabled must be ignored.
      seed_load_a = (i == 1); seed_val_a = 32'h1234_5678;
      @(negedge clk);
      n_checks++; if (rd_valid_a !== 1'b0) begin n_errors++; $display("FAIL freeze_valid[%0d]: got %b required 0", i, rd_valid_a); end
      n_checks++; if (rd_data_a !== mdl_a) begin n_errors++; $display("FAIL freeze_data[%0d]: got %h required %h", i, rd_data_a, mdl_a); end
      n_checks++; if (draw_cnt_a !== cnt_a) begin n_errors++; $display("FAIL freeze_cnt[%0d]: got %0d required %0d", i, draw_cnt_a, cnt_a); end
      next_cycle();
    end
    seed_load_a = 1'b0; en_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mdl_a);
      @(negedge clk);
      pop_exp(e);
      n_checks++; if (rd_data_a !== e) begin n_errors++; $display("FAIL unfreeze_data[%0d]: got %h required %h", i, rd_data_a, e); end
      mdl_a = ref_shift(mdl_a); cnt_a++;
      next_cycle();
    end
  endtask

  task automatic test_mid_reset();
    rd_ready_a = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if (rd_data_a !== SEED_C) begin n_errors++; $display("FAIL midrst_data: got %h required %h", rd_data_a, SEED_C); end
    n_checks++; if (draw_cnt_a !== 32'd0) begin n_errors++; $display("FAIL midrst_cnt: got %0d required 0", draw_cnt_a); end
    n_checks++; if (rd_valid_a !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b required 0", rd_valid_a); end
    rd_ready_a = 1'b0; rd_ready_s = 1'b0; rd_ready_w = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdl_a = SEED_C; cnt_a = 0;
    next_cycle();
    @(negedge clk);
    n_checks++; if (rd_data_a !== SEED_C) begin n_errors++; $display("FAIL postrst_data: got %h required %h", rd_data_a, SEED_C); end
    next_cycle();
  endtask

  task automatic test_step();
    logic [31:0] e;
    rd_ready_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ref_adv(SEED_C, 4 * k));
      @(negedge clk);
      pop_exp(e);
      n_checks++; if (rd_valid_s !== 1'b1) begin n_errors++; $display("FAIL step4_valid[%0d]: got %b required 1", k, rd_valid_s); end
      n_checks++; if (rd_data_s !== e) begin n_errors++; $display("FAIL step4_data[%0d]: got %h required %h", k, rd_data_s, e); end
      next_cycle();
    end
    rd_ready_s = 1'b0;
  endtask

  task automatic test_warmup();
    logic [31:0] e;
    en_w = 1'b1; rd_ready_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rd_valid_w !== 1'b0) begin n_errors++; $display("FAIL warm_reset_valid[%0d]: got %b required 0", i, rd_valid_w); end
      next_cycle();
    end
    exp_q.push_back(ref_adv(SEED_C, 3));
    @(negedge clk);
    pop_exp(e);
    n_checks++; if (rd_valid_w !== 1'b1) begin n_errors++; $display("FAIL warm_first_valid: got %b required 1", rd_valid_w); end
    n_checks++; if (rd_data_w !== e) begin n_errors++; $display("FAIL warm_first_data: got %h required %h", rd_data_w, e); end
    next_cycle();
    // Reseed while a transfer is being offered in the same cycle.
    seed_load_w = 1'b1; seed_val_w = 32'h0000_0001;
    @(negedge clk);
    n_checks++; if (draw_cnt_w !== 32'd1) begin n_errors++; $display("FAIL warm_pre_load_cnt: got %0d required 1", draw_cnt_w); end
    next_cycle();
    seed_load_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rd_valid_w !== 1'b0) begin n_errors++; $display("FAIL warm_load_valid[%0d]: got %b required 0", i, rd_valid_w); end
      n_checks++; if (draw_cnt_w !== 32'd0) begin n_errors++; $display("FAIL warm_load_cnt[%0d]: got %0d required 0", i, draw_cnt_w); end
      next_cycle();
    end
    exp_q.push_back(ref_adv(32'h0000_0001, 3));
    @(negedge clk);
    pop_exp(e);
    n_checks++; if (rd_valid_w !== 1'b1) begin n_errors++; $display("FAIL warm_reseed_valid: got %b required 1", rd_valid_w); end
    n_checks++; if (rd_data_w !== e) begin n_errors++; $display("FAIL warm_reseed_data: got %h required %h", rd_data_w, e); end
    n_checks++; if (draw_cnt_w !== 32'd0) begin n_errors++; $display("FAIL warm_reseed_cnt: got %0d required 0", draw_cnt_w); end
    next_cycle();
    rd_ready_w = 1'b0;
  endtask

  task automatic test_lockup();
    logic [31:0] e;
    en_a = 1'b1; rd_ready_a = 1'b0;
    seed_load_a = 1'b1; seed_val_a = 32'h0;
    next_cycle();
    seed_load_a = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    mdl_a = SEED_C;
    @(negedge clk);
    n_checks++; if (lockup_a !== 1'b1) begin n_errors++; $display("FAIL lockup_flag: got %b required 1", lockup_a); end
`else
    mdl_a = 32'h0;
    @(negedge clk);
    n_checks++; if (lockup_a !== 1'b0) begin n_errors++; $display("FAIL lockup_flag: got %b required 0", lockup_a); end
`endif
    n_checks++; if (rd_data_a !== mdl_a) begin n_errors++; $display("FAIL lockup_data: got %h required %h", rd_data_a, mdl_a); end
    n_checks++; if (draw_cnt_a !== 32'd0) begin n_errors++; $display("FAIL lockup_cnt: got %0d required 0", draw_cnt_a); end
    next_cycle();
    rd_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mdl_a);
      @(negedge clk);
      pop_exp(e);
      n_checks++; if (rd_data_a !== e) begin n_errors++; $display("FAIL lockup_draw[%0d]: got %h required %h", i, rd_data_a, e); end
      mdl_a = ref_shift(mdl_a);
      next_cycle();
    end
    rd_ready_a = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_enable_freeze();
    test_mid_reset();
    test_step();
    test_warmup();
    test_lockup();
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
